// File: rtl/move_cmd_sequencer_pkg.sv
// move_cmd_sequencer_pkg: command codes, map cell IDs and sequencer FSM states
package move_cmd_sequencer_pkg;
    localparam int POS_W = 7;
    localparam logic [2:0] CMD_RIGHT = 3'd1, CMD_LEFT = 3'd2, CMD_UP = 3'd3, CMD_DOWN = 3'd4, CMD_EXIT = 3'd5;
    localparam logic [15:0] CELL_UNKNOWN = 16'd0, CELL_CURRENT = 16'd1, CELL_ENTRANCE = 16'd2,
                            CELL_EXIT = 16'd3, CELL_BLANK = 16'd4, CELL_WALL = 16'd5;
    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, ISSUE, HALT} state_t;
endpackage

// File: rtl/move_cmd_sequencer_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO, head visible on dout while not empty
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/move_cmd_sequencer.sv
// move_cmd_sequencer: buffers raw commands, validates moves against bounds and walls, issues legal ones
module move_cmd_sequencer
    import move_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GRID_W = 10,
    parameter int GRID_H = 10,
    parameter int START_POS = 50,
    parameter int WALL_ID = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [15:0]      cmd_data,
    output logic             cmd_ready,
    output logic [POS_W-1:0] map_addr,
    input  logic [15:0]      map_data,
    output logic             mv_valid,
    output logic [2:0]       mv_code,
    output logic [POS_W-1:0] mv_pos,
    input  logic             mv_ready,
    output logic [POS_W-1:0] cur_pos,
    output logic [7:0]       reject_cnt,
    output logic             halted
);
    localparam logic [POS_W-1:0] GW = POS_W'(GRID_W), COL_MAX = POS_W'(GRID_W - 1),
                                 ROW_MAX = POS_W'(GRID_H - 1), START = POS_W'(START_POS);
    localparam logic [15:0] WALL = 16'(WALL_ID);
    state_t state, state_n;
    logic [15:0] head;
    logic [2:0] code, cmd_q, cmd_n, mv_code_n;
    logic [POS_W-1:0] tgt_q, tgt_n, mv_pos_n, cur_pos_n, col, row, step, target;
    logic [7:0] reject_n;
    logic full, empty, pop, hi_zero, is_move, is_exit, in_bounds, reject;

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(cmd_valid && cmd_ready), .pop(pop),
        .din(cmd_data), .dout(head), .full(full), .empty(empty)
    );

    assign halted = state == HALT;
    assign cmd_ready = !full && !halted;
    assign mv_valid = state == ISSUE;
    assign map_addr = state == LOOKUP ? tgt_q : '0;
    assign pop = state == IDLE && !empty;
    assign code = head[2:0];
    assign hi_zero = head[15:3] == '0;
    assign is_move = hi_zero && code >= CMD_RIGHT && code <= CMD_DOWN;
    assign is_exit = hi_zero && code == CMD_EXIT;
    assign col = cur_pos % GW;
    assign row = cur_pos / GW;
    // Bounds are judged on row/column so edge moves never wrap into the neighbouring row
    assign in_bounds = code == CMD_RIGHT ? col < COL_MAX :
                       code == CMD_LEFT  ? col != '0 :
                       code == CMD_UP    ? row != '0 : row < ROW_MAX;
    assign step = (code == CMD_RIGHT || code == CMD_LEFT) ? POS_W'(1) : GW;
    assign target = (code == CMD_RIGHT || code == CMD_DOWN) ? cur_pos + step : cur_pos - step;
    assign reject_n = reject_cnt + 8'(reject && reject_cnt != 8'hFF);

    always_comb begin
        state_n = state;
        cmd_n = cmd_q;
        tgt_n = tgt_q;
        mv_code_n = mv_code;
        mv_pos_n = mv_pos;
        cur_pos_n = cur_pos;
        reject = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                if (is_move && in_bounds) begin
                    state_n = LOOKUP;
                    cmd_n = code;
                    tgt_n = target;
                end else if (is_exit) begin
                    state_n = ISSUE;
                    mv_code_n = CMD_EXIT;
                    mv_pos_n = cur_pos;
                end else reject = 1'b1;
            end
            LOOKUP: state_n = CHECK;
            CHECK: if (map_data == WALL) begin
                reject = 1'b1;
                state_n = IDLE;
            end else begin
                state_n = ISSUE;
                mv_code_n = cmd_q;
                mv_pos_n = tgt_q;
            end
            ISSUE: if (mv_ready) begin
                cur_pos_n = mv_pos;
                state_n = mv_code == CMD_EXIT ? HALT : IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cmd_q <= '0;
            tgt_q <= '0;
            mv_code <= '0;
            mv_pos <= START;
            cur_pos <= START;
            reject_cnt <= '0;
        end else begin
            state <= state_n;
            cmd_q <= cmd_n;
            tgt_q <= tgt_n;
            mv_code <= mv_code_n;
            mv_pos <= mv_pos_n;
            cur_pos <= cur_pos_n;
            reject_cnt <= reject_n;
        end
    end
endmodule

// File: tb/tb_move_cmd_sequencer.sv
// tb_move_cmd_sequencer: table vectors, directed corner sequences and random traffic vs a move-level model
module tb_move_cmd_sequencer;
    logic clk = 0, rst_n = 0, cmd_valid = 0, mv_ready = 0;
    logic cmd_ready, mv_valid, halted;
    logic [15:0] cmd_data = 0, map_data = 0, md_next = 0;
    logic [6:0] map_addr, mv_pos, cur_pos;
    logic [2:0] mv_code;
    logic [7:0] reject_cnt;
    logic [15:0] map [100];
    bit saw_addr [128];
    logic [9:0] got [$];
    logic [9:0] expq [$];
    logic [15:0] acc [$];
    int n_vec = 0, n_err = 0;
    int m_pos, m_rej;
    bit m_halt;

    typedef struct {
        logic [15:0] cmd;
        int wall;
        int n;
        logic [9:0] mv;
        logic [7:0] rej;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    move_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .map_addr(map_addr), .map_data(map_data), .mv_valid(mv_valid), .mv_code(mv_code),
        .mv_pos(mv_pos), .mv_ready(mv_ready), .cur_pos(cur_pos), .reject_cnt(reject_cnt), .halted(halted)
    );

    // Observe handshakes and map reads 1 time unit before each rising edge
    always begin
        @(negedge clk);
        #4;
        md_next = (map_addr < 7'd100) ? map[map_addr] : 16'hFFFF;
        saw_addr[map_addr] = 1'b1;
        if (rst_n && mv_valid && mv_ready) got.push_back({mv_code, mv_pos});
        if (rst_n && cmd_valid && cmd_ready) acc.push_back(cmd_data);
    end

    always @(posedge clk) map_data <= md_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        cmd_valid = 0;
        mv_ready = 0;
        @(negedge clk);
        rst_n = 1;
        got.delete();
        acc.delete();
        foreach (saw_addr[i]) saw_addr[i] = 1'b0;
    endtask

    task automatic blank_map();
        foreach (map[i]) map[i] = 16'd4;
    endtask

    task automatic push(input logic [15:0] c);
        cmd_valid = 1;
        cmd_data = c;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!mv_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(mv_valid), 1);
    endtask

    function automatic logic [15:0] rnd_cmd();
        int r;
        r = $urandom_range(0, 99);
        if (r < 22) return 16'd1;
        if (r < 44) return 16'd2;
        if (r < 66) return 16'd3;
        if (r < 88) return 16'd4;
        if (r < 90) return 16'd5;
        if (r < 93) return 16'd0;
        if (r < 96) return 16'($urandom_range(6, 7));
        return 16'($urandom);
    endfunction

    // Replays the accepted command stream move by move on a 10x10 grid
    task automatic model();
        int c, t, col, row;
        bit ok;
        m_pos = 50;
        m_rej = 0;
        m_halt = 0;
        expq.delete();
        foreach (acc[i]) begin
            c = int'(acc[i]);
            if (m_halt) continue;
            if (c >= 1 && c <= 4) begin
                col = m_pos % 10;
                row = m_pos / 10;
                ok = (c == 1) ? col < 9 : (c == 2) ? col > 0 : (c == 3) ? row > 0 : row < 9;
                t = (c == 1) ? m_pos + 1 : (c == 2) ? m_pos - 1 : (c == 3) ? m_pos - 10 : m_pos + 10;
                if (ok && map[t] != 16'd5) begin
                    expq.push_back({3'(c), 7'(t)});
                    m_pos = t;
                end else if (m_rej < 255) m_rej++;
            end else if (c == 5) begin
                expq.push_back({3'd5, 7'(m_pos)});
                m_halt = 1;
            end else if (m_rej < 255) m_rej++;
        end
    endtask

    initial begin
        int lat;
        blank_map();
        tbl[0]  = '{16'd1, -1, 1, {3'd1, 7'd51}, 8'd0};
        tbl[1]  = '{16'd2, -1, 0, 10'd0, 8'd1};
        tbl[2]  = '{16'd3, -1, 1, {3'd3, 7'd40}, 8'd0};
        tbl[3]  = '{16'd4, -1, 1, {3'd4, 7'd60}, 8'd0};
        tbl[4]  = '{16'd5, -1, 1, {3'd5, 7'd50}, 8'd0};
        tbl[5]  = '{16'd0, -1, 0, 10'd0, 8'd1};
        tbl[6]  = '{16'd9, -1, 0, 10'd0, 8'd1};
        tbl[7]  = '{16'h0101, -1, 0, 10'd0, 8'd1};
        tbl[8]  = '{16'd1, 51, 0, 10'd0, 8'd1};
        tbl[9]  = '{16'd3, 40, 0, 10'd0, 8'd1};
        tbl[10] = '{16'd4, 51, 1, {3'd4, 7'd60}, 8'd0};

        do_reset();
        chk("rst_mv_valid", 32'(mv_valid), 0);
        chk("rst_mv_code", 32'(mv_code), 0);
        chk("rst_mv_pos", 32'(mv_pos), 50);
        chk("rst_map_addr", 32'(map_addr), 0);
        chk("rst_reject", 32'(reject_cnt), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_cur_pos", 32'(cur_pos), 50);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            blank_map();
            if (tbl[i].wall >= 0) map[tbl[i].wall] = 16'd5;
            mv_ready = 1;
            push(tbl[i].cmd);
            repeat (8) @(negedge clk);
            chk($sformatf("tbl%0d_moves", i), got.size(), tbl[i].n);
            if (tbl[i].n == 1 && got.size() == 1) chk($sformatf("tbl%0d_mv", i), 32'(got[0]), 32'(tbl[i].mv));
            chk($sformatf("tbl%0d_cur_pos", i), 32'(cur_pos), tbl[i].n == 1 ? 32'(tbl[i].mv[6:0]) : 50);
            chk($sformatf("tbl%0d_reject", i), 32'(reject_cnt), 32'(tbl[i].rej));
            chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].n == 1 && tbl[i].mv[9:7] == 3'd5));
        end
        blank_map();

        do_reset();
        push(16'd1);
        lat = 0;
        while (!mv_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("move_latency", lat, 3);
        do_reset();
        push(16'd5);
        lat = 0;
        while (!mv_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("exit_latency", lat, 1);

        do_reset();
        mv_ready = 1;
        push(16'd1);
        push(16'd1);
        push(16'd4);
        for (int i = 0; i < 40 && got.size() < 3; i++) @(negedge clk);
        chk("seq_moves", got.size(), 3);
        if (got.size() == 3) begin
            chk("seq_mv0", 32'(got[0]), 32'({3'd1, 7'd51}));
            chk("seq_mv1", 32'(got[1]), 32'({3'd1, 7'd52}));
            chk("seq_mv2", 32'(got[2]), 32'({3'd4, 7'd62}));
        end
        chk("seq_cur_pos", 32'(cur_pos), 62);
        chk("seq_reject", 32'(reject_cnt), 0);

        do_reset();
        mv_ready = 1;
        push(16'd2);
        repeat (6) @(negedge clk);
        chk("left_edge_no_read", 32'(saw_addr[49]), 0);
        chk("left_edge_moves", got.size(), 0);
        chk("left_edge_reject", 32'(reject_cnt), 1);
        chk("left_edge_cur_pos", 32'(cur_pos), 50);

        do_reset();
        map[51] = 16'd5;
        mv_ready = 1;
        push(16'd1);
        repeat (6) @(negedge clk);
        chk("wall_addr_seen", 32'(saw_addr[51]), 1);
        chk("wall_moves", got.size(), 0);
        chk("wall_reject", 32'(reject_cnt), 1);
        map[51] = 16'd4;

        do_reset();
        push(16'd1);
        wait_valid("stall_valid_rise");
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(mv_valid), 1);
            chk("stall_code", 32'(mv_code), 1);
            chk("stall_pos", 32'(mv_pos), 51);
            chk("stall_cur_pos", 32'(cur_pos), 50);
            cmd_valid = k < 4;
            cmd_data = 16'd4;
            @(negedge clk);
        end
        cmd_valid = 0;
        @(negedge clk);
        chk("stall_full_ready", 32'(cmd_ready), 0);
        mv_ready = 1;
        @(negedge clk);
        chk("stall_handshake_pos", 32'(cur_pos), 51);
        for (int i = 0; i < 60 && got.size() < 5; i++) @(negedge clk);
        chk("stall_drain_moves", got.size(), 5);
        chk("stall_drain_pos", 32'(cur_pos), 91);

        do_reset();
        mv_ready = 1;
        push(16'd9);
        push(16'd5);
        repeat (4) @(negedge clk);
        chk("exit_reject", 32'(reject_cnt), 1);
        chk("exit_moves", got.size(), 1);
        if (got.size() == 1) chk("exit_mv", 32'(got[0]), 32'({3'd5, 7'd50}));
        chk("exit_halted", 32'(halted), 1);
        chk("exit_cmd_ready", 32'(cmd_ready), 0);
        cmd_valid = 1;
        cmd_data = 16'd1;
        repeat (5) @(negedge clk);
        cmd_valid = 0;
        repeat (5) @(negedge clk);
        chk("halt_moves", got.size(), 1);
        chk("halt_cur_pos", 32'(cur_pos), 50);
        chk("halt_still", 32'(halted), 1);

        do_reset();
        push(16'd0);
        push(16'd1);
        push(16'd3);
        wait_valid("rst_issue_valid");
        chk("rst_issue_pre_reject", 32'(reject_cnt), 1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("rst_issue_valid", 32'(mv_valid), 0);
        chk("rst_issue_cur_pos", 32'(cur_pos), 50);
        chk("rst_issue_reject", 32'(reject_cnt), 0);
        chk("rst_issue_ready", 32'(cmd_ready), 1);
        mv_ready = 1;
        repeat (10) @(negedge clk);
        chk("rst_issue_fifo_empty", got.size(), 0);

        do_reset();
        cmd_valid = 1;
        cmd_data = 16'd0;
        repeat (270) @(negedge clk);
        cmd_valid = 0;
        repeat (4) @(negedge clk);
        chk("reject_saturate", 32'(reject_cnt), 255);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            foreach (map[i]) map[i] = ($urandom_range(0, 3) == 0) ? 16'd5 : 16'($urandom_range(0, 6));
            repeat (200) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_data = rnd_cmd();
                mv_ready = $urandom_range(0, 3) != 0;
                @(negedge clk);
            end
            cmd_valid = 0;
            mv_ready = 1;
            repeat (60) @(negedge clk);
            model();
            chk($sformatf("rnd%0d_moves", r), got.size(), expq.size());
            for (int i = 0; i < got.size() && i < expq.size(); i++)
                chk($sformatf("rnd%0d_mv%0d", r, i), 32'(got[i]), 32'(expq[i]));
            chk($sformatf("rnd%0d_cur_pos", r), 32'(cur_pos), m_pos);
            chk($sformatf("rnd%0d_reject", r), 32'(reject_cnt), m_rej);
            chk($sformatf("rnd%0d_halted", r), 32'(halted), 32'(m_halt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
